// File: rtl/data_bus_ctrl_pkg.sv
// rtl/data_bus_ctrl_pkg.sv - shared defaults, ControlBus bit indices and FSM state encoding
package data_bus_ctrl_pkg;

    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_TIMEOUT   = 64;

    localparam int CTRL_WR = 2;
    localparam int CTRL_RD = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } busState_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// rtl/bus_timeout_cnt.sv - counts WAIT cycles; expired flags the LIMIT-th cycle without completion
module bus_timeout_cnt #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // count holds (elapsed WAIT cycles - 1), so expired is high during the LIMIT-th one
    assign expired = (count == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - CPU-side data bus controller: one memory access per request, stall, timeout abort
module data_bus_ctrl
    import data_bus_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 InputClk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] AddressBus,
    input  logic [BIT_WIDTH-1:0] DataBusOut,
    input  logic [2:0]           ControlBus,
    output logic [BIT_WIDTH-1:0] DataBusIn,
    output logic                 Stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BIT_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0] mem_wdata,
    input  logic [BIT_WIDTH-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 BusError,
    output logic [BIT_WIDTH-1:0] AccessCount,
    output logic [BIT_WIDTH-1:0] StallCycles
);

    busState_t state;
    busState_t nextState;

    logic wrReq;
    logic rdReq;
    logic anyReq;
    logic waitExpired;
    logic unusedCtrlBit;

    assign wrReq         = ControlBus[CTRL_WR];
    assign rdReq         = ControlBus[CTRL_RD];
    assign anyReq        = wrReq | rdReq;
    assign unusedCtrlBit = ControlBus[0];

    bus_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk     (InputClk),
        .rst     (rst),
        .clear   (state != WAIT),
        .enable  (state == WAIT),
        .expired (waitExpired)
    );

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Stall rises in the request cycle itself so the CPU never commits past an access
    always_comb begin
        nextState = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) begin
                    nextState = WAIT;
                    Stall     = !rst;
                end
            end
            WAIT: begin
                Stall = !rst;
                if (mem_ack || waitExpired) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            DataBusIn   <= '0;
            BusError    <= 1'b0;
            AccessCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        mem_req   <= 1'b1;
                        mem_we    <= wrReq;
                        mem_addr  <= AddressBus;
                        mem_wdata <= DataBusOut;
                        // simultaneous read+write: write wins, read is dropped and flagged
                        if (wrReq && rdReq) begin
                            BusError <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        AccessCount <= AccessCount + BIT_WIDTH'(1);
                        if (!mem_we) begin
                            DataBusIn <= mem_rdata;
                        end
                    end else if (waitExpired) begin
                        mem_req  <= 1'b0;
                        BusError <= 1'b1;
                        if (!mem_we) begin
                            DataBusIn <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            StallCycles <= '0;
        end else if (Stall) begin
            StallCycles <= StallCycles + BIT_WIDTH'(1);
        end
    end

endmodule

// File: doc/data_bus_ctrl.md
DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, datapath width of address and data.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, maximum cycles waiting for mem_ack before abort.
REQ-003 InputClk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 AddressBus  in  BIT_WIDTH  CPU data address.
REQ-006 DataBusOut  in  BIT_WIDTH  CPU store data.
REQ-007 ControlBus  in  3  [2]=write request, [1]=read request, [0] ignored.
REQ-008 DataBusIn  out  BIT_WIDTH  load data returned to CPU.
REQ-009 Stall  out  1  CPU hold; CPU does not advance PC or commit while high.
REQ-010 mem_req  out  1  request to memory, held until mem_ack.
REQ-011 mem_we  out  1  1=write, 0=read; valid while mem_req.
REQ-012 mem_addr  out  BIT_WIDTH  latched address; mem_wdata  out  BIT_WIDTH  latched store data.
REQ-013 mem_rdata  in  BIT_WIDTH  read data, sampled only in the cycle mem_ack=1.
REQ-014 mem_ack  in  1  one-cycle completion pulse from memory.
REQ-015 BusError  out  1  sticky error flag; AccessCount  out  BIT_WIDTH  completed accesses; StallCycles  out  BIT_WIDTH  cycles with Stall=1.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-017 In IDLE with ControlBus[2] or ControlBus[1] high, Stall SHALL be 1 combinationally in that same cycle; on the edge the block latches address/data/direction, asserts mem_req, goes to WAIT.
REQ-018 If ControlBus[2] and ControlBus[1] are both high, write SHALL win, the read is dropped, BusError set.
REQ-019 In WAIT, Stall=1 and mem_req/mem_we/mem_addr/mem_wdata SHALL remain stable until the cycle mem_ack=1.
REQ-020 On mem_ack in WAIT: mem_req drops next edge, DataBusIn loads mem_rdata (read) or is unchanged (write), AccessCount increments, state goes to DONE.
REQ-021 Minimum access latency SHALL be: request cycle in IDLE, >=1 WAIT cycle, one DONE cycle; Stall low only in DONE.
REQ-022 In DONE, Stall=0, ControlBus SHALL be ignored (no re-issue of the same access), next state IDLE unconditionally.
REQ-023 A wait counter SHALL count WAIT cycles; reaching TIMEOUT without mem_ack SHALL abort: mem_req dropped, DataBusIn=0 for reads, BusError set, AccessCount unchanged, go to DONE.
REQ-024 mem_ack outside WAIT SHALL be ignored.
REQ-025 StallCycles SHALL increment every cycle Stall=1; both counters wrap modulo 2^BIT_WIDTH.
REQ-026 DataBusIn SHALL hold its last value between reads.

Reset
REQ-027 On rst=1, asynchronously: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, DataBusIn=0, BusError=0, counters 0, wait counter 0.
REQ-028 Reset mid-access SHALL drop mem_req immediately; no completion is recorded; a late mem_ack after reset release is ignored.
REQ-029 Stall SHALL be 0 while rst=1.

Structure
REQ-030 State encodings and ControlBus bit indices (CTRL_WR=2, CTRL_RD=1) SHALL live in the shared defs header alongside BIT_WIDTH.
REQ-031 The wait/timeout counter SHALL be a sub-module bus_timeout_cnt (clear, enable, expired output).
REQ-032 The block SHALL sit between CPU and DataMemory in the top-level sim; DataMemory receives mem_* signals through a thin ack-generating wrapper in the bench.

Verification
REQ-033 Read, ack after 2 WAIT cycles, mem_rdata=0x0000_00A5 -> DataBusIn=0xA5 in DONE, Stall high 3 cycles, AccessCount=1.
REQ-034 Write addr 0x10, data 0x1234_5678, ack after 1 cycle -> mem_we=1, mem_addr=0x10, mem_wdata=0x12345678 stable until ack, DataBusIn unchanged.
REQ-035 ControlBus=3'b110 -> write performed, BusError=1, one access counted.
REQ-036 No ack, TIMEOUT=4 -> mem_req drops after 4 WAIT cycles, read returns 0, BusError=1, AccessCount=0.
REQ-037 rst asserted mid-WAIT, ack pulsed after release -> mem_req=0 at once, state IDLE, counters 0, ack ignored.
REQ-038 Back-to-back reads with ControlBus held high -> exactly one access per DONE, no duplicate request in DONE.
